// File: rtl/lift_input_pingpong_buffer.sv
// Ping-pong input buffer: wide words fill one bank while the other streams out one coefficient
// per cycle, lane-major within each address, with valid/ready handshakes on both sides.
module lift_input_pingpong_buffer #(
  parameter int unsigned LANES = 8,
  parameter int unsigned LW    = 30,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned SW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [LANES*LW-1:0]   wr_din,
  input  logic                  wr_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [LW-1:0]         rd_data,
  output logic [SW-1:0]         rd_lane,
  output logic [AW-1:0]         rd_addr,
  output logic                  rd_last,
  output logic [1:0]            banks_full
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  bank_st_e             st_q [2];
  logic [AW:0]          cnt_q [2];
  logic [1:0]           jc_q;
  logic                 init_q;
  logic                 wr_bank_q;
  logic                 rd_bank_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        ra_q;
  logic [SW-1:0]        rl_q;
  logic [LANES*LW-1:0]  mem [2*DEPTH];

  logic                 wr_fire;
  logic                 wr_close;
  logic                 rd_avail;
  logic                 fetch;
  logic                 fetch_last;
  logic [LANES*LW-1:0]  rd_word;
  logic [LW-1:0]        rd_coef;

  assign wr_ready = init_q && (st_q[wr_bank_q] == StEmpty || st_q[wr_bank_q] == StFilling);
  assign wr_fire  = wr_valid && wr_ready && !clr;
  assign wr_close = wr_fire && (wr_last || wr_ptr_q == AW'(DEPTH - 1));

  // A bank closed on the previous edge is held back one cycle, fixing fill-to-output latency.
  assign rd_avail = (st_q[rd_bank_q] == StFull && !jc_q[rd_bank_q]) ||
                    st_q[rd_bank_q] == StDraining;
  assign fetch      = !clr && rd_avail && (!rd_valid || rd_ready);
  assign fetch_last = fetch && ({1'b0, ra_q} == cnt_q[rd_bank_q] - 1'b1) &&
                      rl_q == SW'(LANES - 1);

  assign rd_word = mem[{rd_bank_q, ra_q}];
  assign rd_coef = rd_word[rl_q*LW +: LW];

  always_comb begin
    banks_full = 2'd0;
    for (int b = 0; b < 2; b++) begin
      if (st_q[b] == StFull || st_q[b] == StDraining) banks_full = banks_full + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_q, wr_ptr_q}] <= wr_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= StEmpty;
        cnt_q[b] <= '0;
      end
      jc_q      <= '0;
      init_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      ra_q      <= '0;
      rl_q      <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_lane   <= '0;
      rd_addr   <= '0;
      rd_last   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      jc_q   <= '0;
      if (clr) begin
        for (int b = 0; b < 2; b++) begin
          st_q[b]  <= StEmpty;
          cnt_q[b] <= '0;
        end
        wr_bank_q <= 1'b0;
        rd_bank_q <= 1'b0;
        wr_ptr_q  <= '0;
        ra_q      <= '0;
        rl_q      <= '0;
        rd_valid  <= 1'b0;
        rd_data   <= '0;
        rd_lane   <= '0;
        rd_addr   <= '0;
        rd_last   <= 1'b0;
      end else begin
        // Writer and reader never own the same bank, so both may update st_q this cycle.
        if (wr_fire) begin
          if (wr_close) begin
            st_q[wr_bank_q]  <= StFull;
            cnt_q[wr_bank_q] <= {1'b0, wr_ptr_q} + 1'b1;
            jc_q[wr_bank_q]  <= 1'b1;
            wr_bank_q        <= ~wr_bank_q;
            wr_ptr_q         <= '0;
          end else begin
            st_q[wr_bank_q] <= StFilling;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
          end
        end
        if (fetch) begin
          rd_valid <= 1'b1;
          rd_data  <= rd_coef;
          rd_lane  <= rl_q;
          rd_addr  <= ra_q;
          rd_last  <= fetch_last;
          if (fetch_last) begin
            st_q[rd_bank_q] <= StEmpty;
            rd_bank_q       <= ~rd_bank_q;
            ra_q            <= '0;
            rl_q            <= '0;
          end else begin
            st_q[rd_bank_q] <= StDraining;
            if (rl_q == SW'(LANES - 1)) begin
              rl_q <= '0;
              ra_q <= ra_q + 1'b1;
            end else begin
              rl_q <= rl_q + 1'b1;
            end
          end
        end else if (rd_ready) begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule
